// File: rtl/pool_writer.sv
// pool_writer: packs pooled vectors into full-width buffer lines and writes them out
// Ports:
//   clk, reset           sole clock (rising edge), asynchronous active-high reset
//   start                one-cycle layer request; latches base_addr and pool_window_size
//   base_addr            first write address of the layer
//   pool_window_size     window W (1, 2 or 4; anything else behaves as 1)
//   in_data              pooled vector; lanes 0..DESIGN_SIZE/W-1 are meaningful
//   in_data_available    in_data/validity_mask valid this cycle
//   validity_mask        per-lane validity of in_data
//   done_pool_in         no more vectors for this layer
//   bram_addr/wdata/we   registered line write; we is all-zero when not writing
//   busy                 high outside IDLE
//   done_write           one-cycle end-of-layer pulse
//   line_count           lines written this layer (wraps at 2^16)
module pool_writer #(
    parameter int DWIDTH        = 8,
    parameter int DESIGN_SIZE   = 16,
    parameter int MASK_WIDTH    = 16,
    parameter int MAX_BITS_POOL = 3,
    parameter int AWIDTH        = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AWIDTH-1:0]             base_addr,
    input  logic [MAX_BITS_POOL-1:0]      pool_window_size,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] in_data,
    input  logic                          in_data_available,
    input  logic [MASK_WIDTH-1:0]         validity_mask,
    input  logic                          done_pool_in,
    output logic [AWIDTH-1:0]             bram_addr,
    output logic [DESIGN_SIZE*DWIDTH-1:0] bram_wdata,
    output logic [MASK_WIDTH-1:0]         bram_we,
    output logic                          busy,
    output logic                          done_write,
    output logic [15:0]                   line_count
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    localparam int VW = DESIGN_SIZE * DWIDTH;
    localparam int L2 = DESIGN_SIZE / 2;
    localparam int L4 = DESIGN_SIZE / 4;
    state_t state;
    logic [AWIDTH-1:0] addr;
    logic w2, w4, pend, full, wr;
    logic [1:0] slot, slot_n, last_slot;
    logic [VW-1:0] line, line_n, cur_line;
    logic [MASK_WIDTH-1:0] mask, mask_n, cur_mask;
    // Each line lane k comes from one fixed vector lane for a given W; the
    // slot decides whether this capture fills it. A fresh line starts from zero
    // so a flushed partial line carries zeros and no enables in unfilled lanes.
    for (genvar k = 0; k < DESIGN_SIZE; k++) begin : g_lane
        localparam int S2 = k / L2;
        localparam int S4 = k / L4;
        localparam int J2 = k % L2;
        localparam int J4 = k % L4;
        logic hit;
        assign hit = w4 ? (slot == S4[1:0]) : w2 ? (slot == S2[1:0]) : 1'b1;
        assign line_n[k*DWIDTH +: DWIDTH] = hit ?
            (w4 ? in_data[J4*DWIDTH +: DWIDTH] : w2 ? in_data[J2*DWIDTH +: DWIDTH] : in_data[k*DWIDTH +: DWIDTH]) :
            (slot == 2'd0 ? '0 : line[k*DWIDTH +: DWIDTH]);
        assign mask_n[k] = hit ?
            (w4 ? validity_mask[J4] : w2 ? validity_mask[J2] : validity_mask[k]) :
            ((slot != 2'd0) & mask[k]);
    end
    assign last_slot = w4 ? 2'd3 : w2 ? 2'd1 : 2'd0;
    assign full      = in_data_available && slot == last_slot;
    assign slot_n    = in_data_available ? (full ? 2'd0 : slot + 2'd1) : slot;
    assign cur_line  = in_data_available ? line_n : line;
    assign cur_mask  = in_data_available ? mask_n : mask;
    // A completed line always writes; end of input also flushes a partial line.
    assign wr        = full || (done_pool_in && slot_n != 2'd0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            w2         <= 1'b0;
            w4         <= 1'b0;
            pend       <= 1'b0;
            slot       <= '0;
            line       <= '0;
            mask       <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            bram_we    <= '0;
            busy       <= 1'b0;
            done_write <= 1'b0;
            line_count <= '0;
        end else begin
            bram_we    <= '0;
            done_write <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    addr       <= base_addr;
                    w2         <= pool_window_size == MAX_BITS_POOL'(2);
                    w4         <= pool_window_size == MAX_BITS_POOL'(4);
                    slot       <= '0;
                    line       <= '0;
                    mask       <= '0;
                    line_count <= '0;
                    busy       <= 1'b1;
                    state      <= COLLECT;
                end
                COLLECT: begin
                    if (in_data_available) begin
                        line <= line_n;
                        mask <= mask_n;
                        slot <= slot_n;
                    end
                    if (wr) begin
                        bram_we    <= cur_mask;
                        bram_wdata <= cur_line;
                        bram_addr  <= addr;
                        addr       <= addr + 1'b1;
                        line_count <= line_count + 16'd1;
                    end
                    // With a write still on the bus, the pulse waits one more cycle.
                    if (done_pool_in) begin
                        state      <= DONE;
                        done_write <= !wr;
                        pend       <= wr;
                    end
                end
                DONE: begin
                    done_write <= pend;
                    pend       <= 1'b0;
                    if (!pend) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_writer.sv
// tb_pool_writer: scoreboard bench for pool_writer
module tb_pool_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic in_data_available = 1'b0;
    logic done_pool_in = 1'b0;
    logic [9:0] base_addr = '0;
    logic [2:0] pool_window_size = '0;
    logic [127:0] in_data = '0;
    logic [15:0] validity_mask = '0;
    logic [9:0] bram_addr;
    logic [127:0] bram_wdata;
    logic [15:0] bram_we;
    logic busy, done_write;
    logic [15:0] line_count;
    typedef struct {
        int c;
        logic [9:0] a;
        logic [127:0] d;
        logic [15:0] m;
    } wr_t;
    wr_t q[$];
    wr_t e;
    int cyc = 0;
    int checks = 0;
    int passed = 0;
    logic [15:0] vmask [8];
    logic [15:0] last_we = '0;

    pool_writer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .pool_window_size(pool_window_size), .in_data(in_data),
        .in_data_available(in_data_available), .validity_mask(validity_mask),
        .done_pool_in(done_pool_in), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_we(bram_we), .busy(busy), .done_write(done_write), .line_count(line_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bram_we !== 16'h0) begin
            last_we = bram_we;
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_write cyc=%0d addr=%h we=%h", cyc, bram_addr, bram_we);
            end else begin
                e = q.pop_front();
                if (cyc !== e.c || bram_addr !== e.a || bram_wdata !== e.d || bram_we !== e.m)
                    $display("FAIL write cyc=%0d addr=%h we=%h data=%h required cyc=%0d addr=%h we=%h data=%h",
                             cyc, bram_addr, bram_we, bram_wdata, e.c, e.a, e.m, e.d);
                else passed++;
            end
        end
    end

    task automatic run_layer(input logic [9:0] base, input logic [2:0] w, input int nvec,
                             input int off, input bit sim_done, input bit restart);
        int weff, lanes, slot, lines, e_edge, last_wr, done_edge, seen, pulses;
        logic [9:0] a;
        logic [127:0] line;
        logic [15:0] lm;
        weff = (w == 3'd2) ? 2 : (w == 3'd4) ? 4 : 1;
        lanes = 16 / weff;
        a = base; slot = 0; lines = 0; line = '0; lm = '0; last_wr = -1; e_edge = -1;
        @(posedge clk) #1;
        start = 1'b1; base_addr = base; pool_window_size = w;
        @(posedge clk) #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start got=%b required=1", busy); else passed++;
        for (int v = 0; v < nvec; v++) begin
            for (int j = 0; j < 16; j++) in_data[j*8 +: 8] = (j < lanes) ? 8'(v*lanes + j + 1 + off) : 8'hEE;
            validity_mask = vmask[v];
            in_data_available = 1'b1;
            done_pool_in = sim_done && v == nvec - 1;
            if (restart && v == 0) begin
                start = 1'b1; base_addr = base + 10'h100; pool_window_size = 3'd4;
            end
            for (int j = 0; j < lanes; j++) begin
                line[(slot*lanes + j)*8 +: 8] = in_data[j*8 +: 8];
                lm[slot*lanes + j] = vmask[v][j];
            end
            slot++;
            e_edge = cyc + 1;
            if (slot == weff) begin
                q.push_back(wr_t'{e_edge, a, line, lm});
                last_wr = e_edge; a++; lines++; slot = 0; line = '0; lm = '0;
            end
            @(posedge clk) #1;
            start = 1'b0;
        end
        in_data_available = 1'b0;
        if (!sim_done) begin
            done_pool_in = 1'b1;
            e_edge = cyc + 1;
            @(posedge clk) #1;
        end
        done_pool_in = 1'b0;
        if (slot > 0) begin
            q.push_back(wr_t'{e_edge, a, line, lm});
            last_wr = e_edge; lines++;
        end
        done_edge = (last_wr == e_edge) ? e_edge + 1 : e_edge;
        seen = -1; pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_write === 1'b1) begin
                pulses++;
                if (seen < 0) seen = cyc;
            end
        end
        checks++;
        if (seen !== done_edge) $display("FAIL done_timing cyc=%0d required=%0d", seen, done_edge); else passed++;
        checks++;
        if (pulses !== 1) $display("FAIL done_pulses got=%0d required=1", pulses); else passed++;
        checks++;
        if (line_count !== 16'(lines)) $display("FAIL line_count got=%0d required=%0d", line_count, lines); else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_after_done got=%b required=0", busy); else passed++;
        checks++;
        if (q.size() != 0) begin
            $display("FAIL missing_writes got=%0d pending required=0", q.size());
            q.delete();
        end else passed++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bram_addr, bram_wdata, bram_we, busy, done_write, line_count} !== '0)
            $display("FAIL reset_state addr=%h we=%h busy=%b done=%b lc=%0d required all zero",
                     bram_addr, bram_we, busy, done_write, line_count);
        else passed++;
        @(posedge clk) #1;
        reset = 1'b0;
    endtask

    task automatic test_w1();
        for (int i = 0; i < 8; i++) vmask[i] = 16'hFFFF;
        run_layer(10'h010, 3'd1, 3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_w2_pack();
        for (int i = 0; i < 8; i++) vmask[i] = 16'hFFFF;
        run_layer(10'h020, 3'd2, 2, 0, 1'b0, 1'b0);
        checks++;
        if (bram_wdata !== 128'h100f0e0d0c0b0a090807060504030201)
            $display("FAIL w2_line got=%h required=100f0e0d0c0b0a090807060504030201", bram_wdata);
        else passed++;
    endtask

    task automatic test_w4_flush();
        for (int i = 0; i < 8; i++) vmask[i] = 16'hFFFF;
        run_layer(10'h030, 3'd4, 3, 40, 1'b0, 1'b0);
        checks++;
        if (last_we !== 16'h0FFF) $display("FAIL flush_we got=%h required=0fff", last_we); else passed++;
        checks++;
        if (bram_wdata[127:96] !== 32'h0) $display("FAIL flush_zero got=%h required=0", bram_wdata[127:96]); else passed++;
    endtask

    task automatic test_mask();
        vmask[0] = 16'h00F0; vmask[1] = 16'h00FF;
        run_layer(10'h040, 3'd2, 2, 7, 1'b0, 1'b0);
        checks++;
        if (last_we !== 16'hFFF0) $display("FAIL mask_we got=%h required=fff0", last_we); else passed++;
    endtask

    task automatic test_addr_wrap();
        for (int i = 0; i < 8; i++) vmask[i] = 16'hFFFF;
        run_layer(10'h3FF, 3'd1, 2, 90, 1'b0, 1'b0);
        checks++;
        if (bram_addr !== 10'h000) $display("FAIL addr_wrap got=%h required=000", bram_addr); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) vmask[i] = 16'(32'hA5C3 >> i) | 16'h0101;
        run_layer(10'h100, 3'd2, 3, 3, 1'b1, 1'b0);
        run_layer(10'h110, 3'd4, 8, 11, 1'b1, 1'b0);
        run_layer(10'h120, 3'd1, 4, 60, 1'b0, 1'b0);
    endtask

    task automatic test_restart_w3();
        for (int i = 0; i < 8; i++) vmask[i] = 16'(i * 16'h1357 + 16'h8001);
        run_layer(10'h200, 3'd3, 3, 20, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        int pulses;
        for (int i = 0; i < 8; i++) vmask[i] = 16'hFFFF;
        @(posedge clk) #1;
        start = 1'b1; base_addr = 10'h050; pool_window_size = 3'd4;
        @(posedge clk) #1;
        start = 1'b0; in_data = {8{16'h3344}}; validity_mask = 16'hFFFF; in_data_available = 1'b1;
        @(posedge clk) #1;
        in_data_available = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bram_addr, bram_wdata, bram_we, busy, done_write, line_count} !== '0)
            $display("FAIL mid_reset addr=%h we=%h busy=%b lc=%0d required all zero", bram_addr, bram_we, busy, line_count);
        else passed++;
        in_data_available = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0; in_data_available = 1'b0; done_pool_in = 1'b1;
        @(posedge clk) #1;
        done_pool_in = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_write === 1'b1 || busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL idle_after_reset got=%0d active cycles required=0", pulses); else passed++;
    endtask

    initial begin
        test_reset();
        test_w1();
        test_w2_pack();
        test_w4_flush();
        test_mask();
        test_addr_wrap();
        test_back_to_back();
        test_restart_w3();
        test_mid_reset();
        run_layer(10'h300, 3'd4, 4, 5, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
